// File: rtl/cfe_wait_pkg.sv
// Shared types and default configuration for the CFE wait-feedback controller.
package cfe_wait_pkg;

  typedef enum logic {
    ST_START = 1'b0,
    ST_READY = 1'b1
  } cfe_state_e;

  localparam int unsigned CFE_DEF_RESET_THR    = 32'h200;
  localparam int unsigned CFE_DEF_INCR_THR     = 32'h50;
  localparam int unsigned CFE_DEF_INCR_STEP    = 32'h100;
  localparam int unsigned CFE_DEF_DEFAULT_WAIT = 32'h100;
  localparam int unsigned CFE_DEF_MAX_WAIT     = 32'h1000;

  function automatic int unsigned cfe_ch_bits(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/cfe_wait_ch.sv
// One CFE channel: tracks the last FO estimate, adapts the wait interval and
// counts down to the next "re-estimate due" point.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_START | no reference FO yet; lane shows default wait, due asserted
//   ST_READY | reference held; wait adapts on samples, due when count = 0
module cfe_wait_ch
  import cfe_wait_pkg::*;
#(
  parameter int CFE_NBW_FO  = 15,
  parameter int CFE_NBW_LAT = 32
) (
  input  logic                   clk,
  input  logic                   rst_async_n,
  input  logic                   i_hit,
  input  logic                   i_clear,
  input  logic [CFE_NBW_FO-1:0]  i_fo_value,
  input  logic                   i_mode,
  input  logic [CFE_NBW_FO-1:0]  i_reset_thr,
  input  logic [CFE_NBW_FO-1:0]  i_incr_thr,
  input  logic [CFE_NBW_LAT-1:0] i_incr_step,
  input  logic [CFE_NBW_LAT-1:0] i_default_wait,
  input  logic [CFE_NBW_LAT-1:0] i_max_wait,
  output logic [CFE_NBW_LAT-1:0] o_wait,
  output logic                   o_due
);

  cfe_state_e             state_q, state_d;
  logic [CFE_NBW_FO-1:0]  last_fo_q, last_fo_d;
  logic [CFE_NBW_LAT-1:0] wait_q, wait_d;
  logic [CFE_NBW_LAT-1:0] cnt_q, cnt_d;

  logic [CFE_NBW_FO:0]    fo_diff;
  logic [CFE_NBW_FO:0]    abs_diff;
  logic [CFE_NBW_LAT-1:0] ceil_wait;
  logic [CFE_NBW_LAT:0]   grow_sum;
  logic [CFE_NBW_LAT:0]   decay_diff;
  logic [CFE_NBW_LAT-1:0] grow_wait;
  logic [CFE_NBW_LAT-1:0] decay_wait;
  logic [CFE_NBW_LAT-1:0] next_wait;

  // Difference is taken one bit wider than the FO so the magnitude never wraps.
  always_comb begin
    fo_diff  = {i_fo_value[CFE_NBW_FO-1], i_fo_value} - {last_fo_q[CFE_NBW_FO-1], last_fo_q};
    abs_diff = fo_diff[CFE_NBW_FO] ? (~fo_diff + (CFE_NBW_FO+1)'(1)) : fo_diff;

    ceil_wait  = (i_max_wait < i_default_wait) ? i_default_wait : i_max_wait;
    grow_sum   = {1'b0, wait_q} + {1'b0, i_incr_step};
    grow_wait  = (grow_sum > {1'b0, ceil_wait}) ? ceil_wait : grow_sum[CFE_NBW_LAT-1:0];
    decay_diff = {1'b0, wait_q} - {1'b0, i_incr_step};
    decay_wait = (decay_diff[CFE_NBW_LAT] || (decay_diff[CFE_NBW_LAT-1:0] < i_default_wait))
                 ? i_default_wait : decay_diff[CFE_NBW_LAT-1:0];

    if (abs_diff > {1'b0, i_reset_thr}) begin
      next_wait = i_default_wait;
    end else if (abs_diff < {1'b0, i_incr_thr}) begin
      next_wait = grow_wait;
    end else if (i_mode) begin
      next_wait = decay_wait;
    end else begin
      next_wait = wait_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_fo_d = last_fo_q;
    wait_d    = wait_q;
    cnt_d     = (cnt_q != '0) ? (cnt_q - CFE_NBW_LAT'(1)) : cnt_q;

    if (i_clear) begin
      state_d   = ST_START;
      last_fo_d = '0;
      wait_d    = i_default_wait;
      cnt_d     = '0;
    end else if (i_hit) begin
      last_fo_d = i_fo_value;
      case (state_q)
        ST_START: begin
          state_d = ST_READY;
          wait_d  = i_default_wait;
          cnt_d   = i_default_wait;
        end
        ST_READY: begin
          wait_d = next_wait;
          cnt_d  = next_wait;
        end
        default: state_d = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q   <= ST_START;
      last_fo_q <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_fo_q <= last_fo_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_wait = (state_q == ST_START) ? i_default_wait : wait_q;
  assign o_due  = (state_q == ST_START) || (cnt_q == '0);

endmodule

// File: rtl/cfe_wait_feedback_mc.sv
// Multi-channel CFE wait feedback: decodes the sample channel, replicates the
// per-channel controller and applies the feedback-enable override on the lanes.
module cfe_wait_feedback_mc
  import cfe_wait_pkg::*;
#(
  parameter int CFE_NBW_FO  = 15,
  parameter int CFE_NBW_LAT = 32,
  parameter int CFE_NCH     = 4,
  localparam int CFE_NBW_CH = cfe_ch_bits(CFE_NCH)
) (
  input  logic                           clk,
  input  logic                           rst_async_n,
  input  logic                           i_valid,
  input  logic [CFE_NBW_CH-1:0]          i_ch,
  input  logic [CFE_NBW_FO-1:0]          i_fo_value,
  input  logic                           i_enable,
  input  logic                           i_mode,
  input  logic                           i_clear,
  input  logic [CFE_NBW_FO-1:0]          i_reset_thr,
  input  logic [CFE_NBW_FO-1:0]          i_incr_thr,
  input  logic [CFE_NBW_LAT-1:0]         i_incr_step,
  input  logic [CFE_NBW_LAT-1:0]         i_default_wait,
  input  logic [CFE_NBW_LAT-1:0]         i_max_wait,
  output logic [CFE_NCH*CFE_NBW_LAT-1:0] o_wait,
  output logic [CFE_NCH-1:0]             o_due
);

  for (genvar k = 0; k < CFE_NCH; k++) begin : g_ch
    logic                   hit;
    logic [CFE_NBW_LAT-1:0] ch_wait;

    // Indices at or above CFE_NCH never match any lane, so they are dropped.
    assign hit = i_valid && (i_ch == CFE_NBW_CH'(k));

    cfe_wait_ch #(
      .CFE_NBW_FO  (CFE_NBW_FO),
      .CFE_NBW_LAT (CFE_NBW_LAT)
    ) u_ch (
      .clk            (clk),
      .rst_async_n    (rst_async_n),
      .i_hit          (hit),
      .i_clear        (i_clear),
      .i_fo_value     (i_fo_value),
      .i_mode         (i_mode),
      .i_reset_thr    (i_reset_thr),
      .i_incr_thr     (i_incr_thr),
      .i_incr_step    (i_incr_step),
      .i_default_wait (i_default_wait),
      .i_max_wait     (i_max_wait),
      .o_wait         (ch_wait),
      .o_due          (o_due[k])
    );

    assign o_wait[k*CFE_NBW_LAT +: CFE_NBW_LAT] = i_enable ? ch_wait : i_default_wait;
  end

endmodule

// File: tb/tb_cfe_wait_feedback_mc.sv
// Directed-vector bench for cfe_wait_feedback_mc with hand-computed expectations.
module tb_cfe_wait_feedback_mc;
  import cfe_wait_pkg::*;

  localparam int NBW_FO  = 15;
  localparam int NBW_LAT = 32;
  localparam int NCH     = 4;
  localparam int NBW_CH  = 2;

  logic                     clk;
  logic                     rst_async_n;
  logic                     i_valid;
  logic [NBW_CH-1:0]        i_ch;
  logic [NBW_FO-1:0]        i_fo_value;
  logic                     i_enable;
  logic                     i_mode;
  logic                     i_clear;
  logic [NBW_FO-1:0]        i_reset_thr;
  logic [NBW_FO-1:0]        i_incr_thr;
  logic [NBW_LAT-1:0]       i_incr_step;
  logic [NBW_LAT-1:0]       i_default_wait;
  logic [NBW_LAT-1:0]       i_max_wait;
  logic [NCH*NBW_LAT-1:0]   o_wait;
  logic [NCH-1:0]           o_due;

  int n_vec;
  int n_err;

  localparam logic [NCH*NBW_LAT-1:0] ALL_DEF = {4{32'h100}};

  cfe_wait_feedback_mc #(
    .CFE_NBW_FO  (NBW_FO),
    .CFE_NBW_LAT (NBW_LAT),
    .CFE_NCH     (NCH)
  ) dut (
    .clk            (clk),
    .rst_async_n    (rst_async_n),
    .i_valid        (i_valid),
    .i_ch           (i_ch),
    .i_fo_value     (i_fo_value),
    .i_enable       (i_enable),
    .i_mode         (i_mode),
    .i_clear        (i_clear),
    .i_reset_thr    (i_reset_thr),
    .i_incr_thr     (i_incr_thr),
    .i_incr_step    (i_incr_step),
    .i_default_wait (i_default_wait),
    .i_max_wait     (i_max_wait),
    .o_wait         (o_wait),
    .o_due          (o_due)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NBW_LAT-1:0] lane(input int k);
    return o_wait[k*NBW_LAT +: NBW_LAT];
  endfunction

  // Presents one sample on a negedge and returns at the following negedge,
  // where the registered result of that sample is visible.
  task automatic send(input logic [NBW_CH-1:0] ch, input logic [NBW_FO-1:0] fo);
    @(negedge clk);
    i_valid    = 1'b1;
    i_ch       = ch;
    i_fo_value = fo;
    @(negedge clk);
    i_valid    = 1'b0;
  endtask

  task automatic chk_lane(input string name, input int k, input logic [NBW_LAT-1:0] exp);
    n_vec++;
    if (lane(k) !== exp) begin
      n_err++;
      $display("FAIL %s: lane%0d got 0x%0h expected 0x%0h", name, k, lane(k), exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_async_n = 1'b0;
    @(negedge clk);
    rst_async_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (o_due !== 4'hF) begin
      n_err++;
      $display("FAIL reset_due: got 0x%0h expected 0xf", o_due);
    end
    n_vec++;
    if (o_wait !== ALL_DEF) begin
      n_err++;
      $display("FAIL reset_wait: got 0x%0h expected 0x%0h", o_wait, ALL_DEF);
    end
  endtask

  task automatic test_basic();
    send(2'd0, 15'h10);
    chk_lane("basic_first", 0, 32'h100);
    n_vec++;
    if (o_due[0] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_due0: got %0b expected 0", o_due[0]);
    end
    send(2'd0, 15'h20);
    chk_lane("basic_grow", 0, 32'h200);
  endtask

  task automatic test_saturate();
    logic [NBW_LAT-1:0] exp;
    send(2'd1, 15'h0);
    send(2'd1, 15'h300);
    chk_lane("sat_reset", 1, 32'h100);
    exp = 32'h100;
    for (int i = 0; i < 17; i++) begin
      send(2'd1, 15'h300);
      exp = (exp + 32'h100 > 32'h1000) ? 32'h1000 : exp + 32'h100;
      chk_lane("sat_step", 1, exp);
    end
    chk_lane("sat_other_ch0", 0, 32'h200);
  endtask

  task automatic test_mid_band();
    i_mode = 1'b1;
    send(2'd2, 15'h40);
    send(2'd2, 15'h40);
    send(2'd2, 15'h40);
    chk_lane("decay_pre", 2, 32'h300);
    send(2'd2, 15'h140);
    chk_lane("decay_step", 2, 32'h200);
    send(2'd2, 15'h240);
    chk_lane("decay_floor1", 2, 32'h100);
    send(2'd2, 15'h340);
    chk_lane("decay_floor2", 2, 32'h100);
    i_mode = 1'b0;
    send(2'd2, 15'h340);
    chk_lane("hold_grow", 2, 32'h200);
    send(2'd2, 15'h440);
    chk_lane("hold_mid", 2, 32'h200);
    send(2'd2, 15'h640);
    chk_lane("eq_reset_thr", 2, 32'h200);
    send(2'd2, 15'h690);
    chk_lane("eq_incr_thr", 2, 32'h200);
    send(2'd2, 15'h891);
    chk_lane("above_reset_thr", 2, 32'h100);
    send(2'd2, 15'h8E0);
    chk_lane("below_incr_thr", 2, 32'h200);
  endtask

  task automatic test_no_wrap();
    send(2'd3, 15'h3FFF);
    chk_lane("wrap_start", 3, 32'h100);
    send(2'd3, 15'h3FFF);
    chk_lane("wrap_grow", 3, 32'h200);
    send(2'd3, 15'h4000);
    chk_lane("wrap_reset", 3, 32'h100);
    chk_lane("wrap_other_ch2", 2, 32'h200);
  endtask

  task automatic test_due_timer();
    int cyc;
    cyc = 0;
    while (o_due[3] === 1'b0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc != 32'h100) begin
      n_err++;
      $display("FAIL due_timer: due rose after %0d cycles expected 256", cyc);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    i_clear    = 1'b1;
    i_valid    = 1'b1;
    i_ch       = 2'd0;
    i_fo_value = 15'h10;
    @(negedge clk);
    i_clear = 1'b0;
    i_valid = 1'b0;
    n_vec++;
    if (o_due !== 4'hF) begin
      n_err++;
      $display("FAIL clear_due: got 0x%0h expected 0xf", o_due);
    end
    n_vec++;
    if (o_wait !== ALL_DEF) begin
      n_err++;
      $display("FAIL clear_wait: got 0x%0h expected 0x%0h", o_wait, ALL_DEF);
    end
    send(2'd0, 15'h10);
    chk_lane("clear_restart", 0, 32'h100);
    n_vec++;
    if (o_due !== 4'hE) begin
      n_err++;
      $display("FAIL clear_restart_due: got 0x%0h expected 0xe", o_due);
    end
  endtask

  task automatic test_enable_and_async_reset();
    send(2'd1, 15'h0);
    send(2'd1, 15'h0);
    send(2'd1, 15'h0);
    chk_lane("en_grown", 1, 32'h300);
    i_enable = 1'b0;
    #1;
    n_vec++;
    if (o_wait !== ALL_DEF) begin
      n_err++;
      $display("FAIL disable_mux: got 0x%0h expected 0x%0h", o_wait, ALL_DEF);
    end
    send(2'd1, 15'h0);
    chk_lane("disabled_lane1", 1, 32'h100);
    i_enable = 1'b1;
    #1;
    chk_lane("reenable_lane1", 1, 32'h400);
    chk_lane("reenable_lane0", 0, 32'h100);
    @(posedge clk);
    #3;
    rst_async_n = 1'b0;
    #1;
    n_vec++;
    if (o_due !== 4'hF) begin
      n_err++;
      $display("FAIL async_reset_due: got 0x%0h expected 0xf", o_due);
    end
    n_vec++;
    if (o_wait !== ALL_DEF) begin
      n_err++;
      $display("FAIL async_reset_wait: got 0x%0h expected 0x%0h", o_wait, ALL_DEF);
    end
    @(negedge clk);
    rst_async_n = 1'b1;
  endtask

  task automatic test_ceiling_below_default();
    i_max_wait = 32'h80;
    send(2'd0, 15'h5);
    send(2'd0, 15'h5);
    chk_lane("ceil_floor", 0, 32'h100);
    i_max_wait = 32'(CFE_DEF_MAX_WAIT);
    send(2'd0, 15'h5);
    chk_lane("ceil_restored", 0, 32'h200);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_async_n    = 1'b0;
    i_valid        = 1'b0;
    i_ch           = '0;
    i_fo_value     = '0;
    i_enable       = 1'b1;
    i_mode         = 1'b0;
    i_clear        = 1'b0;
    i_reset_thr    = 15'(CFE_DEF_RESET_THR);
    i_incr_thr     = 15'(CFE_DEF_INCR_THR);
    i_incr_step    = 32'(CFE_DEF_INCR_STEP);
    i_default_wait = 32'(CFE_DEF_DEFAULT_WAIT);
    i_max_wait     = 32'(CFE_DEF_MAX_WAIT);

    test_reset();
    test_basic();
    test_saturate();
    test_mid_band();
    test_no_wrap();
    test_due_timer();
    test_clear();
    test_enable_and_async_reset();
    test_ceiling_below_default();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cfe_wait_feedback_mc.md
CFE_WAIT_FEEDBACK_MC -- requirements
Module: cfe_wait_feedback_mc

Interface
REQ-001 SHALL have parameter CFE_NBW_FO, default 15: frequency-offset width, two's complement.
REQ-002 SHALL have parameter CFE_NBW_LAT, default 32: wait/latency width, unsigned.
REQ-003 SHALL have parameter CFE_NCH, default 4: number of independent CFE channels (1..16); CFE_NBW_CH = max(1, clog2(CFE_NCH)) is derived.
REQ-004 SHALL have ports, in this order:
  - clk  in  1  single clock, rising edge.
  - rst_async_n  in  1  reset, asynchronous assert, active low.
  - i_valid  in  1  FO sample valid this cycle.
  - i_ch  in  CFE_NBW_CH  channel index of the sample.
  - i_fo_value  in  CFE_NBW_FO  signed FO estimate.
  - i_enable  in  1  feedback enable.
  - i_mode  in  1  mid-band policy: 0 = hold, 1 = decay.
  - i_clear  in  1  synchronous clear of all channels.
  - i_reset_thr  in  CFE_NBW_FO  unsigned; |diff| above this resets wait.
  - i_incr_thr  in  CFE_NBW_FO  unsigned; |diff| below this grows wait.
  - i_incr_step  in  CFE_NBW_LAT  grow/decay step.
  - i_default_wait  in  CFE_NBW_LAT  floor and start value.
  - i_max_wait  in  CFE_NBW_LAT  ceiling.
  - o_wait  out  CFE_NCH*CFE_NBW_LAT  per-channel wait; channel k in bits [k*CFE_NBW_LAT +: CFE_NBW_LAT].
  - o_due  out  CFE_NCH  per-channel "re-estimate due" level.

Function
REQ-005 SHALL keep, per channel: state {START, READY}, last_fo, wait register, countdown counter (CFE_NBW_LAT bits).
REQ-006 SHALL treat a sample as addressed to channel k when i_valid=1 and i_ch=k; i_ch >= CFE_NCH SHALL be ignored with no state change.
REQ-007 In START, an addressed sample SHALL store last_fo=i_fo_value, load the counter with i_default_wait, move to READY, and leave wait at i_default_wait.
REQ-008 In READY, an addressed sample SHALL compute diff = i_fo_value - last_fo in CFE_NBW_FO+1 signed bits, take |diff| (CFE_NBW_FO+1 unsigned, no wrap), and update last_fo.
REQ-009 If |diff| > i_reset_thr, wait SHALL become i_default_wait.
REQ-010 Otherwise, if |diff| < i_incr_thr, wait SHALL become min(wait + i_incr_step, i_max_wait), with the sum computed in CFE_NBW_LAT+1 bits (no overflow wrap).
REQ-011 Otherwise (mid band):
  - i_mode=0: wait SHALL hold.
  - i_mode=1: wait SHALL become max(wait - i_incr_step, i_default_wait); underflow SHALL yield i_default_wait.
REQ-012 Threshold priority SHALL be reset > increase > mid band; |diff| equal to a threshold SHALL fall into the mid band.
REQ-013 On every READY-state addressed sample, the counter SHALL load the newly computed wait value.
REQ-014 Otherwise each counter SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-015 o_due[k] SHALL be 1 when channel k is in START, or is in READY with counter=0; otherwise 0.
REQ-016 Latency: o_wait and o_due SHALL reflect an addressed sample on the cycle after it is sampled (registered outputs, 1-cycle latency).
REQ-017 Non-addressed channels SHALL be unaffected by a sample, except for counter decrement.
REQ-018 i_enable=0 SHALL force every o_wait lane to i_default_wait (combinational mux); internal state and counters SHALL keep updating.
REQ-019 i_clear=1 SHALL, at the next edge, return all channels to START with wait=i_default_wait, counter=0, last_fo=0; i_clear SHALL take priority over a simultaneous i_valid.
REQ-020 Configuration inputs SHALL be sampled live each cycle; no shadowing.
REQ-021 If i_max_wait < i_default_wait, the ceiling SHALL be i_default_wait.

Reset
REQ-022 rst_async_n=0 SHALL asynchronously set all channels to START, last_fo=0, counter=0, wait=0.
REQ-023 While a channel is in START, its o_wait lane SHALL output i_default_wait.
REQ-024 After reset, o_due SHALL be all ones.
REQ-025 Reset asserted mid-operation SHALL discard all channel history.

Structure
REQ-026 Package cfe_wait_pkg SHALL hold the state enum (START/READY) and the default configuration constants (0x200, 0x50, 0x100, 0x100, 0x1000).
REQ-027 Per-channel logic SHALL be the sub-module cfe_wait_ch, instantiated CFE_NCH times by a generate loop; the top level holds only decode, the enable mux and packing.

Verification
REQ-028 Config 0x200/0x50/0x100/0x100/0x1000, ch0 FO 0x10 then 0x20 -> o_wait[0]: 0x100, then 0x200; o_due[0]=0 after the first sample.
REQ-029 ch1 samples 0, 0x300 -> wait 0x100. Then 17 samples of 0x300 -> wait saturates at 0x1000, never above.
REQ-030 i_mode=1, ch2 at wait 0x300, sample diff 0x100 -> wait 0x200. Repeated mid-band samples -> floor 0x100.
REQ-031 FO 0x3FFF then 0x4000 (diff -0x7FFF) -> |diff| = 0x7FFF, not wrapped -> reset to default.
REQ-032 ch3 wait 0x100 with no further samples -> o_due[3] rises exactly 0x100 cycles after the update. i_clear together with i_valid -> all channels START, o_due=0xF.
REQ-033 i_enable=0 after growth -> all lanes read 0x100. Re-enable -> grown values reappear. Async reset mid-count -> o_due=0xF immediately.
